// File: rtl/syscall_pkg.sv
// syscall_pkg: service codes, ASCII constants and FSM state type for syscall_console
package syscall_pkg;
    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
    localparam logic [7:0]  ASCII_NL       = 8'h0A;
    typedef enum logic [1:0] {IDLE, SEND, HALTED} state_t;
endpackage

// File: rtl/hex_to_ascii.sv
// hex_to_ascii: maps a 4-bit nibble to its lowercase ASCII hex digit
// ports: nibble (in, 4) value 0..15; ascii (out, 8) '0'..'9' or 'a'..'f'
module hex_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    // 8'h57 + 10 lands on 'a'
    assign ascii = (nibble < 4'd10) ? 8'h30 + {4'h0, nibble} : 8'h57 + {4'h0, nibble};
endmodule

// File: rtl/syscall_console.sv
// syscall_console: console/exit service unit driven by syscall with v0/a0 register taps
// ports: clk, reset (sync, active-high); syscall, v0 (service code), a0 (argument) from the core;
//        stall, halt, err_unsupported to the core; tx_data/tx_valid/tx_ready byte stream to the sink
module syscall_console
    import syscall_pkg::*;
#(
    parameter bit NEWLINE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        stall,
    output logic        halt,
    output logic        err_unsupported,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    state_t      state;
    logic [31:0] arg;
    logic [3:0]  cnt;
    logic [3:0]  code;
    logic        is_int, is_char, is_exit, known, last, fire;
    logic [7:0]  hex, cur;

    assign is_int  = v0 == SYS_PRINT_INT;
    assign is_char = v0 == SYS_PRINT_CHAR;
    assign is_exit = v0 == SYS_EXIT;
    assign known   = is_int || is_char || is_exit;

    // counter 0 selects arg[31:28], counter 7 selects arg[3:0]
    hex_to_ascii u_hex (
        .nibble(arg[{~cnt[2:0], 2'b00} +: 4]),
        .ascii (hex)
    );

    assign last    = (code == SYS_PRINT_CHAR[3:0]) ? cnt == 4'd0 : cnt == (NEWLINE_EN ? 4'd8 : 4'd7);
    assign cur     = (code == SYS_PRINT_CHAR[3:0]) ? arg[7:0] : (cnt[3] ? ASCII_NL : hex);
    assign tx_data = tx_valid ? cur : 8'h00;
    assign fire    = tx_valid && tx_ready && last;
    assign stall   = (state == IDLE && syscall && known) || (state == SEND && !fire) || state == HALTED;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            arg             <= 32'h0;
            cnt             <= 4'h0;
            code            <= 4'h0;
            tx_valid        <= 1'b0;
            halt            <= 1'b0;
            err_unsupported <= 1'b0;
        end else begin
            err_unsupported <= state == IDLE && syscall && !known;
            case (state)
                IDLE: begin
                    if (syscall && (is_int || is_char)) begin
                        arg      <= a0;
                        cnt      <= 4'h0;
                        code     <= v0[3:0];
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end else if (syscall && is_exit) begin
                        halt  <= 1'b1;
                        state <= HALTED;
                    end
                end
                SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (last) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                HALTED: begin
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_syscall_console.sv
// tb_syscall_console: scoreboard bench for syscall_console
module tb_syscall_console;
    logic        clk = 1'b0;
    logic        reset, syscall, tx_ready;
    logic [31:0] v0, a0;
    logic        stall, halt, err_unsupported, tx_valid;
    logic [7:0]  tx_data;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          nbytes = 0;
    logic [7:0]  q[$];
    logic        pend = 1'b0;
    logic [7:0]  held = 8'h00;

    always #5 clk = ~clk;

    syscall_console #(.NEWLINE_EN(1'b1)) dut (
        .clk(clk),
        .reset(reset),
        .syscall(syscall),
        .v0(v0),
        .a0(a0),
        .stall(stall),
        .halt(halt),
        .err_unsupported(err_unsupported),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // byte monitor: pops the scoreboard on each handshake and checks hold-under-backpressure
    always @(negedge clk) begin
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("tx_valid_kept", tx_valid, 1);
                if (tx_valid) chk("tx_hold", tx_data, held);
            end
            if (tx_valid && tx_ready) begin
                nbytes++;
                if (q.size() == 0) chk("q_nonempty", q.size(), 1);
                else chk("tx_byte", tx_data, q.pop_front());
            end
            pend = tx_valid && !tx_ready;
            held = tx_data;
        end
    end

    task automatic run_print(input logic [31:0] code, input logic [31:0] arg, input bit toggle, input int exp_stall);
        string s;
        int    stalls = 0;
        bit    done = 1'b0;
        if (code == 32'd1) begin
            s = $sformatf("%08h", arg);
            for (int i = 0; i < 8; i++) q.push_back(s[i]);
            q.push_back(8'h0A);
        end else begin
            q.push_back(arg[7:0]);
        end
        v0 = code;
        a0 = arg;
        syscall = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            tx_ready = toggle ? (k % 2 == 0) : 1'b1;
            @(negedge clk);
            if (stall) stalls++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        syscall = 1'b0;
        tx_ready = 1'b0;
        chk("stall_cycles", stalls, exp_stall);
        chk("q_drained", q.size(), 0);
        chk("idle_after", tx_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        reset = 1'b1; syscall = 1'b0; v0 = 32'h0; a0 = 32'h0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_halt", halt, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_err", err_unsupported, 0);
        @(posedge clk); #1 reset = 1'b0;

        run_print(32'd1, 32'h12345678, 1'b0, 9);
        run_print(32'd1, 32'hABCDEF01, 1'b1, 18);
        run_print(32'd11, 32'hFFFFFF41, 1'b0, 1);
        run_print(32'd11, 32'h0000007A, 1'b1, 2);

        v0 = 32'd5; syscall = 1'b1;
        @(negedge clk);
        chk("unk_stall", stall, 0);
        chk("unk_err_n", err_unsupported, 0);
        @(posedge clk); #1 syscall = 1'b0;
        @(negedge clk);
        chk("unk_err_n1", err_unsupported, 1);
        chk("unk_valid", tx_valid, 0);
        @(negedge clk);
        chk("unk_err_n2", err_unsupported, 0);

        @(posedge clk); #1;
        s_push_int(32'h12345678);
        v0 = 32'd1; a0 = 32'h12345678; syscall = 1'b1; tx_ready = 1'b1;
        start = nbytes;
        for (int k = 0; k < 50 && nbytes < start + 3; k++) @(negedge clk);
        chk("mid_bytes", nbytes - start, 3);
        @(posedge clk); #1 reset = 1'b1; syscall = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        q.delete();
        @(negedge clk);
        chk("mid_valid", tx_valid, 0);
        chk("mid_stall", stall, 0);
        @(posedge clk); #1;
        run_print(32'd1, 32'h12345678, 1'b0, 9);

        v0 = 32'd10; syscall = 1'b1;
        @(negedge clk);
        chk("exit_stall_n", stall, 1);
        chk("exit_halt_n", halt, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("exit_halt_n1", halt, 1);
        chk("exit_stall_n1", stall, 1);
        @(posedge clk); #1 syscall = 1'b0; v0 = 32'd1; a0 = 32'hDEADBEEF;
        @(posedge clk); #1 syscall = 1'b1; tx_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("halt_no_tx", tx_valid, 0);
            chk("halt_stall", stall, 1);
        end
        @(posedge clk); #1 syscall = 1'b0; reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("halt_cleared", halt, 0);
        chk("stall_cleared", stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    task automatic s_push_int(input logic [31:0] arg);
        string s;
        s = $sformatf("%08h", arg);
        for (int i = 0; i < 8; i++) q.push_back(s[i]);
        q.push_back(8'h0A);
    endtask
endmodule
